// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_rx_pkg: frame format constants and receiver state encoding shared with the matching transmitter
package serial_frame_rx_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SYNC_LEN = 4;
  localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC = 4'b1011;
  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1, PARITY = 2'd2} rx_state_t;
endpackage

// File: rtl/serial_frame_rx_sync_matcher.sv
// sync_matcher: sync-pattern shift register whose match includes the bit arriving on this edge
module sync_matcher #(
  parameter int SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC = 4'b1011
) (
  input  logic CLK,
  input  logic RESET,
  input  logic din,
  input  logic shift,
  input  logic clear,
  output logic match
);
  logic [SYNC_LEN-1:0] shreg;
  assign match = {shreg[SYNC_LEN-2:0], din} == SYNC;
  // clear wins over shift so a finished frame never seeds the next sync
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) shreg <= '0;
    else if (clear) shreg <= '0;
    else if (shift) shreg <= {shreg[SYNC_LEN-2:0], din};
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: sync hunt, MSB-first deserialiser and even-parity check with one-cycle VALID
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC = SYNC_LEN'(DEF_SYNC)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DIN,
  input  logic              DIN_EN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID,
  output logic              PARITY_ERR,
  output logic              BUSY
);
  localparam int CW = $clog2(DATA_W + 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] data_sr;
  logic par;
  logic match;
  sync_matcher #(.SYNC_LEN(SYNC_LEN), .SYNC(SYNC)) u_sync (
    .CLK(CLK),
    .RESET(RESET),
    .din(DIN),
    .shift(DIN_EN && state == HUNT),
    .clear(DIN_EN && state == PARITY),
    .match(match)
  );
  // frame FSM: every transition is strobe-qualified, VALID alone drops without one
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= HUNT;
      cnt <= '0;
      data_sr <= '0;
      par <= 1'b0;
      DATA_OUT <= '0;
      VALID <= 1'b0;
      PARITY_ERR <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (DIN_EN)
        case (state)
          HUNT:
            if (match) begin
              state <= DATA;
              cnt <= '0;
              par <= 1'b0;
              BUSY <= 1'b1;
            end
          DATA: begin
            data_sr <= {data_sr[DATA_W-2:0], DIN};
            par <= par ^ DIN;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) state <= PARITY;
          end
          PARITY: begin
            PARITY_ERR <= par ^ DIN;
            DATA_OUT <= data_sr;
            VALID <= 1'b1;
            BUSY <= 1'b0;
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: vector table, directed frame sequences and random traffic against a bit-queue reference model
module tb_serial_frame_rx;
  localparam int DW = 8;
  localparam int SL = 4;
  localparam logic [SL-1:0] SYNC = 4'b1011;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic DIN = 1'b0;
  logic DIN_EN = 1'b0;
  logic [DW-1:0] DATA_OUT;
  logic VALID, PARITY_ERR, BUSY;
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  bit m_hist[$];
  bit m_dbits[$];
  bit m_in;
  logic [DW-1:0] m_data;
  logic m_valid, m_perr, m_busy;
  serial_frame_rx dut (
    .CLK(CLK),
    .RESET(RESET),
    .DIN(DIN),
    .DIN_EN(DIN_EN),
    .DATA_OUT(DATA_OUT),
    .VALID(VALID),
    .PARITY_ERR(PARITY_ERR),
    .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    bit din;
    bit en;
    logic [DW-1:0] e_data;
    bit e_valid;
    bit e_perr;
    bit e_busy;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: sync seen in the last SL strobed bits since reset/frame end, then DW data bits, then parity
  task automatic model_step(input bit r, input bit d, input bit e);
    logic [SL-1:0] win;
    logic [DW-1:0] w;
    int ones;
    if (!r) begin
      m_hist.delete();
      m_dbits.delete();
      m_in = 0;
      m_data = '0;
      m_valid = 0;
      m_perr = 0;
      m_busy = 0;
      return;
    end
    m_valid = 0;
    if (!e) return;
    if (!m_in) begin
      m_hist.push_back(d);
      if (m_hist.size() > SL) void'(m_hist.pop_front());
      win = '0;
      foreach (m_hist[i]) win = {win[SL-2:0], m_hist[i]};
      if (win == SYNC) begin
        m_in = 1;
        m_dbits.delete();
        m_busy = 1;
      end
    end else if (m_dbits.size() < DW) begin
      m_dbits.push_back(d);
    end else begin
      w = '0;
      ones = int'(d);
      foreach (m_dbits[i]) begin
        w = {w[DW-2:0], m_dbits[i]};
        ones += int'(m_dbits[i]);
      end
      m_data = w;
      m_perr = (ones % 2) != 0;
      m_valid = 1;
      m_busy = 0;
      m_in = 0;
      m_hist.delete();
    end
  endtask
  task automatic cyc(input bit r, input bit d, input bit e);
    RESET = r;
    DIN = d;
    DIN_EN = e;
    @(posedge CLK);
    model_step(r, d, e);
    @(negedge CLK);
    chk("data_out", DATA_OUT, m_data);
    chk("valid", VALID, m_valid);
    chk("parity_err", PARITY_ERR, m_perr);
    chk("busy", BUSY, m_busy);
    if (VALID === 1'b1) vcount++;
  endtask
  task automatic send(input logic [31:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1, v[n-1-i], 1);
      for (int g = 0; g < gap; g++) cyc(1, 1'($urandom), 0);
    end
  endtask
  initial begin
    logic [13:0] bits;
    for (int i = 0; i < 6; i++) cyc(0, 1'($urandom), 1'($urandom));
    chk("reset_data", DATA_OUT, 0);
    chk("reset_busy", BUSY, 0);
    vcount = 0;
    for (int i = 0; i < 20; i++) cyc(1, 1'($urandom), 0);
    chk("reset_no_valid", vcount, 0);
    bits = {4'b1011, 8'hA5, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      vec_t v;
      v.din = bits[13-i];
      v.en = i < 13;
      v.e_data = i >= 12 ? 8'hA5 : 8'h00;
      v.e_valid = i == 12;
      v.e_perr = 0;
      v.e_busy = i >= 3 && i <= 11;
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      cyc(1, tbl[i].din, tbl[i].en);
      chk("tbl_data", DATA_OUT, tbl[i].e_data);
      chk("tbl_valid", VALID, tbl[i].e_valid);
      chk("tbl_perr", PARITY_ERR, tbl[i].e_perr);
      chk("tbl_busy", BUSY, tbl[i].e_busy);
    end
    vcount = 0;
    send({4'b1011, 8'hA5, 1'b1}, 13, 0);
    chk("perr_valid", VALID, 1);
    chk("perr_data", DATA_OUT, 8'hA5);
    chk("perr_flag", PARITY_ERR, 1);
    cyc(1, 0, 0);
    vcount = 0;
    send({4'b1011, 8'hA5, 1'b0}, 13, 3);
    chk("gap_count", vcount, 1);
    chk("gap_data", DATA_OUT, 8'hA5);
    chk("gap_perr", PARITY_ERR, 0);
    vcount = 0;
    send({5'b11011, 8'h3C, 1'b0}, 14, 0);
    chk("hunt_valid", VALID, 1);
    chk("hunt_data", DATA_OUT, 8'h3C);
    send({4'b1011, 8'hFF, 1'b0}, 13, 0);
    chk("b2b_valid", VALID, 1);
    chk("b2b_data", DATA_OUT, 8'hFF);
    chk("b2b_perr", PARITY_ERR, 0);
    chk("b2b_count", vcount, 2);
    send({4'b1011, 4'b0110}, 8, 0);
    chk("mid_busy_pre", BUSY, 1);
    RESET = 0;
    #1;
    chk("async_busy", BUSY, 0);
    chk("async_data", DATA_OUT, 0);
    vcount = 0;
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    send({4'b1011, 8'h5A}, 12, 0);
    chk("mid_no_valid", vcount, 0);
    send(0, 1, 0);
    chk("mid_valid", VALID, 1);
    chk("mid_data", DATA_OUT, 8'h5A);
    chk("mid_perr", PARITY_ERR, 0);
    for (int i = 0; i < 600; i++) cyc($urandom_range(0, 199) != 0, 1'($urandom), $urandom_range(0, 3) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial frame receiver downstream of the single-bit D flip-flop stage. It consumes that stage's registered Q as a serial bit stream.
- Hunts for a sync pattern, deserialises a fixed-width data word MSB-first, then checks an even-parity bit.
- Presents the word with a one-cycle VALID pulse to the parallel consumer.

Parameters:
- DATA_W, 8, data bits per frame (2..16).
- SYNC_LEN, 4, sync pattern length in bits (2..8).
- SYNC, 4'b1011, sync pattern, SYNC_LEN bits wide, first-received bit in MSB.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous reset, active-low: RESET=0 clears all state immediately, independent of CLK.
- DIN  input  1  serial data bit (Q of the upstream flip-flop stage).
- DIN_EN  input  1  bit strobe; DIN is consumed only on rising CLK edges where DIN_EN=1.
- DATA_OUT  output  DATA_W  last received data word.
- VALID  output  1  one-cycle pulse: DATA_OUT/PARITY_ERR updated this cycle.
- PARITY_ERR  output  1  parity result of the last frame; qualified by VALID, held until next frame.
- BUSY  output  1  high from the cycle after sync match until the cycle VALID is asserted (inclusive of last parity sample).

Behaviour:
- Reset (RESET=0): state=HUNT, sync shift register=0, bit counter=0, DATA_OUT=0, VALID=0, PARITY_ERR=0, BUSY=0. Reset asserted mid-frame aborts the frame; no VALID is produced for it.
- States: HUNT, DATA, PARITY. All transitions occur only on edges with DIN_EN=1. VALID is the only output generated off a strobe.
- HUNT:
  - Each strobe shifts DIN into the SYNC_LEN-bit shift register (new bit at LSB).
  - If {shreg[SYNC_LEN-2:0], DIN} == SYNC, go to DATA, clear the bit counter and set BUSY.
  - Matching includes the bit being shifted in on that edge.
- DATA:
  - Each strobe shifts DIN into the data register MSB-first and updates running XOR parity.
  - The counter increments on each strobe. After DATA_W strobes, go to PARITY.
- PARITY:
  - On the strobe, PARITY_ERR <= (running parity XOR DIN) != 0, i.e. even parity over data+parity bit.
  - DATA_OUT <= data register. VALID=1 for exactly that following cycle. BUSY=0.
  - Go to HUNT with the sync shift register cleared to 0. A frame's data bits never contribute to the next sync match.
- Latency: VALID rises on the clock edge that samples the parity bit, so it is visible in the cycle after that strobe.
- DIN_EN=0: all state, counters and shift registers hold. VALID=0 regardless of state.
- Back-to-back frames: the next sync may begin on the strobe immediately after the parity strobe.
- DATA_OUT changes only when VALID is asserted. It is stable at all other times, including during subsequent frames.
- Counter width: $clog2(DATA_W+1). No wrap-around is reachable, because the counter is cleared on sync match.
- X-free: DIN while DIN_EN=0 is ignored.

Decomposition:
- Shared package: state encoding constants (HUNT=2'd0, DATA=2'd1, PARITY=2'd2) and default SYNC/SYNC_LEN/DATA_W constants, for reuse by the matching transmitter.
- One natural sub-module: sync_matcher (SYNC_LEN shift register + comparator, with shift-enable and clear inputs, and match output).
- The FSM, counter and data register stay in the top.

Test Plan:
- Reset: hold RESET=0 with random DIN/DIN_EN, release -> all outputs 0, no VALID for 20 cycles with DIN_EN=0.
- Good frame: strobe 1011, then data 10100101, then parity 0 (one strobe per cycle) -> one VALID pulse one cycle after the parity strobe, DATA_OUT=8'hA5, PARITY_ERR=0, BUSY high for 9 cycles.
- Parity error: same frame with parity bit 1 -> VALID, DATA_OUT=8'hA5, PARITY_ERR=1.
- Gapped strobes: same good frame with DIN_EN=0 for 3 cycles between every bit, and DIN toggled randomly during the gaps -> identical result (8'hA5, PARITY_ERR=0). VALID occurs exactly once.
- Sync hunting and back-to-back:
  - Stream 1 1 0 1 1, then 8'h3C, then parity 0 -> match on the 5th bit, DATA_OUT=8'h3C.
  - Immediately follow with 1011, then 8'hFF, then parity 0 -> second VALID, DATA_OUT=8'hFF, PARITY_ERR=0.
- Reset mid-frame: assert RESET=0 after 4 data bits, release, send a full frame with 8'h5A -> no VALID before the new frame, then DATA_OUT=8'h5A.
